// File: rtl/load_cdb_arbiter.sv
// Round-robin arbiter granting the load unit's single CDB slot to one load buffer entry,
// with a saturating wait counter that flags starved load requests as urgent.
`ifndef LOAD_BUFFER_SZ
`define LOAD_BUFFER_SZ 4
`endif

module load_cdb_arbiter #(
  parameter int LOAD_BUFFER_SZ = `LOAD_BUFFER_SZ,
  parameter int STARVE_LIMIT   = 8,
  parameter int CNT_W          = $clog2(STARVE_LIMIT + 1),
  parameter int PTR_W          = $clog2(LOAD_BUFFER_SZ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LOAD_BUFFER_SZ-1:0] load_cdb_req,
  input  logic                      cdb_slot_free,
  input  logic                      b_mm_mispred,
  output logic [LOAD_BUFFER_SZ-1:0] load_cdb_en,
  output logic                      load_cdb_grant_valid,
  output logic                      load_cdb_urgent
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIMIT);

  if ((1 << PTR_W) != LOAD_BUFFER_SZ || LOAD_BUFFER_SZ < 2) begin : g_size_check
    $error("load_cdb_arbiter: LOAD_BUFFER_SZ must be a power of two >= 2");
  end

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             any_req;
  logic             grant_ok;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand_idx;

  assign any_req  = |load_cdb_req;
  // Mispredict blocks the grant: the winning entry may be squashed this same cycle.
  assign grant_ok = cdb_slot_free & any_req & ~b_mm_mispred & ~reset;

  // Scan from rr_ptr upward; the pointer arithmetic wraps for free at a power-of-two size.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 0; k < LOAD_BUFFER_SZ; k++) begin
      cand_idx = rr_ptr_q + PTR_W'(k);
      if (!grant_found && load_cdb_req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    load_cdb_en = '0;
    for (int i = 0; i < LOAD_BUFFER_SZ; i++) begin
      load_cdb_en[i] = grant_ok & grant_found & (grant_idx == PTR_W'(i));
    end
  end

  assign load_cdb_grant_valid = |load_cdb_en;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_ok && grant_found) begin
      rr_ptr_d = grant_idx + PTR_W'(1);
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (b_mm_mispred) begin
      wait_cnt_d = '0;
    end else if (grant_ok) begin
      wait_cnt_d = '0;
    end else if (!any_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Decoded from the registered count only, so it cannot glitch on this cycle's inputs.
  assign load_cdb_urgent = (wait_cnt_q == WAIT_MAX) & ~reset;

endmodule

// File: tb/tb_load_cdb_arbiter.sv
// Directed bench for load_cdb_arbiter: hand-computed literal expectations plus a
// per-cycle comparison against a simple behavioural model of the arbitration rules.
`timescale 1ns/1ps

module tb_load_cdb_arbiter;

  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic         clock;
  logic         reset;
  logic [N-1:0] load_cdb_req;
  logic         cdb_slot_free;
  logic         b_mm_mispred;
  logic [N-1:0] load_cdb_en;
  logic         load_cdb_grant_valid;
  logic         load_cdb_urgent;

  int checks = 0;
  int errors = 0;

  load_cdb_arbiter #(.LOAD_BUFFER_SZ(N), .STARVE_LIMIT(LIMIT)) dut (
    .clock                (clock),
    .reset                (reset),
    .load_cdb_req         (load_cdb_req),
    .cdb_slot_free        (cdb_slot_free),
    .b_mm_mispred         (b_mm_mispred),
    .load_cdb_en          (load_cdb_en),
    .load_cdb_grant_valid (load_cdb_grant_valid),
    .load_cdb_urgent      (load_cdb_urgent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: pointer and wait count as plain integers.
  int m_ptr  = 0;
  int m_wait = 0;

  function automatic int pick_idx(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_en(input logic [N-1:0] req, input logic free,
                                            input logic mis, input logic rst, input int ptr);
    int g;
    logic [N-1:0] r;
    r = '0;
    g = pick_idx(req, ptr);
    if (!rst && free && !mis && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    int g;
    if (reset) begin
      m_ptr  = 0;
      m_wait = 0;
    end else begin
      g = pick_idx(load_cdb_req, m_ptr);
      if (b_mm_mispred) begin
        m_wait = 0;
      end else if (cdb_slot_free && g >= 0) begin
        m_ptr  = (g + 1) % N;
        m_wait = 0;
      end else if (load_cdb_req == '0) begin
        m_wait = 0;
      end else begin
        m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [N-1:0] e;
    e = model_en(load_cdb_req, cdb_slot_free, b_mm_mispred, reset, m_ptr);
    check("model_en", load_cdb_en, e);
    check("model_gv", {{(N-1){1'b0}}, load_cdb_grant_valid}, {{(N-1){1'b0}}, |e});
    check("model_urgent", {{(N-1){1'b0}}, load_cdb_urgent},
          {{(N-1){1'b0}}, (!reset && m_wait == LIMIT)});
  end

  // Drive one cycle of inputs, check literal expectations mid-cycle, return just after the edge.
  task automatic cyc(input logic [N-1:0] req, input logic free, input logic mis,
                     input logic [N-1:0] e_en, input logic e_urg, input string nm);
    load_cdb_req  = req;
    cdb_slot_free = free;
    b_mm_mispred  = mis;
    @(negedge clock);
    check({nm, "_en"}, load_cdb_en, e_en);
    check({nm, "_gv"}, {{(N-1){1'b0}}, load_cdb_grant_valid}, {{(N-1){1'b0}}, |e_en});
    check({nm, "_urg"}, {{(N-1){1'b0}}, load_cdb_urgent}, {{(N-1){1'b0}}, e_urg});
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    load_cdb_req  = '0;
    cdb_slot_free = 1'b0;
    b_mm_mispred  = 1'b0;
    #2;
    check("reset_en", load_cdb_en, 4'b0000);
    check("reset_urg", {3'b0, load_cdb_urgent}, 4'b0000);
    #5 reset = 1'b0;

    // Rotation
    cyc(4'b1010, 1, 0, 4'b0010, 0, "rot1");
    cyc(4'b1010, 1, 0, 4'b1000, 0, "rot2");
    cyc(4'b1010, 1, 0, 4'b0010, 0, "rot3");
    // Wrap: ptr 2 -> grant 2 -> ptr 3
    cyc(4'b0100, 1, 0, 4'b0100, 0, "wrap_set");
    cyc(4'b0001, 1, 0, 4'b0001, 0, "wrap_0001");
    cyc(4'b0100, 1, 0, 4'b0100, 0, "wrap_set2");
    cyc(4'b1001, 1, 0, 4'b1000, 0, "wrap_1001");

    // Starvation, ptr 0
    for (int i = 0; i < LIMIT; i++) cyc(4'b0100, 0, 0, 4'b0000, 0, "starve");
    for (int i = 0; i < 3; i++) cyc(4'b0100, 0, 0, 4'b0000, 1, "starve_sat");
    cyc(4'b0100, 1, 0, 4'b0100, 1, "starve_grant");
    cyc(4'b0000, 1, 0, 4'b0000, 0, "starve_clear");

    // Mispredict with ptr 1, wait 5 (ptr now 3)
    cyc(4'b0001, 1, 0, 4'b0001, 0, "mis_setp");
    for (int i = 0; i < 5; i++) cyc(4'b1111, 0, 0, 4'b0000, 0, "mis_stall");
    cyc(4'b1111, 1, 1, 4'b0000, 0, "mis_cycle");
    for (int i = 0; i < 4; i++) cyc(4'b1111, 0, 0, 4'b0000, 0, "mis_waitclr");
    cyc(4'b1111, 1, 0, 4'b0010, 0, "mis_ptrhold");
    cyc(4'b0100, 0, 0, 4'b0000, 0, "mis_nofree1");
    cyc(4'b0100, 0, 1, 4'b0000, 0, "mis_nofree2");

    // Async reset with ptr 2, wait 8
    for (int i = 0; i < LIMIT; i++) cyc(4'b1000, 0, 0, 4'b0000, 0, "ar_stall");
    load_cdb_req  = 4'b1111;
    cdb_slot_free = 1'b1;
    b_mm_mispred  = 1'b0;
    @(negedge clock);
    check("ar_pre_en", load_cdb_en, 4'b0100);
    check("ar_pre_urg", {3'b0, load_cdb_urgent}, 4'b0001);
    #2 reset = 1'b1;
    #1;
    check("ar_en", load_cdb_en, 4'b0000);
    check("ar_gv", {3'b0, load_cdb_grant_valid}, 4'b0000);
    check("ar_urg", {3'b0, load_cdb_urgent}, 4'b0000);
    @(posedge clock);
    #2 reset = 1'b0;
    cyc(4'b1111, 1, 0, 4'b0001, 0, "ar_after");

    // Idle, ptr 1
    for (int i = 0; i < 5; i++) cyc(4'b0000, 1, 0, 4'b0000, 0, "idle");
    cyc(4'b1111, 1, 0, 4'b0010, 0, "idle_ptr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_cdb_arbiter.md
Name: load_cdb_arbiter

Overview:
- Round-robin arbiter that selects which load buffer entry drives the single CDB slot allotted to the load unit each cycle.
- Sits between the load buffer's per-entry CDB request vector and the load unit's CDB enable vector.
- Tracks how long load requests have waited without a grant. Raises an urgency flag so the issue-side CDB arbiter can favour the load unit over other functional units.

Parameters:
- LOAD_BUFFER_SZ, default `LOAD_BUFFER_SZ (4 in default config): number of load buffer entries / requesters.
- STARVE_LIMIT, default 8: consecutive un-granted request cycles before urgency asserts.
- CNT_W, default $clog2(STARVE_LIMIT+1): width of the wait counter.
- PTR_W, default $clog2(LOAD_BUFFER_SZ): width of the round-robin pointer.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_cdb_req  input  LOAD_BUFFER_SZ  per-entry request; bit i = entry i holds a completed load result.
- cdb_slot_free  input  1  CDB slot is available to the load unit this cycle.
- b_mm_mispred  input  1  branch mispredict resolved this cycle; load buffer squashes entries.
- load_cdb_en  output  LOAD_BUFFER_SZ  one-hot (or zero) grant; bit i lets entry i drive the CDB this cycle.
- load_cdb_grant_valid  output  1  OR of load_cdb_en.
- load_cdb_urgent  output  1  a load request has waited STARVE_LIMIT cycles; request priority at the CDB.

Behaviour:
- State: rr_ptr (PTR_W bits), wait_cnt (CNT_W bits). No other state.
- Reset (asynchronous, immediate, independent of clock): rr_ptr=0, wait_cnt=0.
- Outputs during reset: load_cdb_en=0, load_cdb_grant_valid=0, load_cdb_urgent=0.
- Grant (combinational, zero-cycle latency):
  - grant_ok = cdb_slot_free & |load_cdb_req & ~b_mm_mispred & ~reset.
  - When grant_ok, load_cdb_en has exactly one bit set: the first set bit of load_cdb_req found scanning indices rr_ptr, rr_ptr+1, ..., wrapping modulo LOAD_BUFFER_SZ.
  - Otherwise load_cdb_en=0.
  - load_cdb_en is never multi-hot and never grants a bit whose request is low.
- Pointer update (rising edge):
  - Grant to index i: rr_ptr <= (i+1) mod LOAD_BUFFER_SZ; i = LOAD_BUFFER_SZ-1 wraps to 0.
  - No grant: rr_ptr holds.
- Wait counter (rising edge), first matching rule applies:
  - b_mm_mispred=1: wait_cnt <= 0.
  - Grant issued: wait_cnt <= 0.
  - load_cdb_req=0: wait_cnt <= 0.
  - Otherwise (requests pending, no grant): wait_cnt <= min(wait_cnt+1, STARVE_LIMIT); saturates, never wraps.
- load_cdb_urgent = (wait_cnt == STARVE_LIMIT); decoded from a register, so it is glitch-free relative to the current-cycle inputs.
  - It stays high until the edge after a grant, a mispredict, or a cycle with no requests.
- Mispredict cycle:
  - No grant, because the load buffer may squash the requesting entry in the same cycle.
  - rr_ptr holds; wait_cnt clears.
- Request dropping without a grant (squash): no special handling; the next cycle's arbitration uses the new vector.
- Simultaneous cdb_slot_free=0 and mispredict: the mispredict rule wins; wait_cnt clears.
- Reset asserted mid-cycle: outputs go to zero without waiting for a clock edge. State resumes from reset values on the first edge after deassertion.
- LOAD_BUFFER_SZ must be a power of two ≥ 2; non-power-of-two configurations are unsupported.

Test Plan:
- Rotation: after reset, load_cdb_req=4'b1010 held, cdb_slot_free=1.
  - Expect load_cdb_en=0010, then 1000, then 0010 on successive cycles.
  - Expect rr_ptr=2, then 0, then 2.
- Wrap: drive rr_ptr to 3 (grant entry 2 first), then req=4'b0001 → en=0001, rr_ptr becomes 1. With rr_ptr=3 and req=4'b1001 → en=1000 (entry 3 before entry 0).
- Starvation: req=4'b0100, cdb_slot_free=0 for 8 cycles.
  - Expect load_cdb_urgent=0 through the 8th cycle, =1 after the 8th edge; wait_cnt saturates at 8 over further stalled cycles.
  - Then cdb_slot_free=1 → en=0100 that cycle, urgent=0 after the next edge.
- Mispredict: req=4'b1111, cdb_slot_free=1, b_mm_mispred=1 with rr_ptr=1, wait_cnt=5.
  - Expect en=0000 and grant_valid=0 that cycle.
  - After the edge: rr_ptr=1, wait_cnt=0.
- Async reset mid-operation: rr_ptr=2, wait_cnt=8 (urgent=1); assert reset between clock edges.
  - Expect en=0, urgent=0, grant_valid=0 immediately.
  - After deassert, req=4'b1111 → en=0001.
- Idle: req=0, cdb_slot_free=1 for 5 cycles → en=0, grant_valid=0, wait_cnt stays 0, rr_ptr unchanged.
